// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter
//   Arbitrates the single fixed-latency-unit writeback port into the scoreboard
//   between three result sources:
//     s0 - single-cycle ALU/branch/CSR results (cannot be back-pressured)
//     s1 - multiplier results
//     s2 - VALU results
//   s1 and s2 each own a 1-entry holding buffer, so a result that loses
//   arbitration is kept rather than dropped. When a held result has waited long
//   enough, stall_issue_o throttles FLU issue so the next cycle can force the
//   held result through ahead of s0.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    drop held results, suppress writeback this cycle
//   sK_valid/result/trans_id_i result sources (K = 0,1,2)
//   s1_ready_o, s2_ready_o     source may present a result (buffer empty)
//   wb_valid/result/trans_id_o writeback to the scoreboard
//   wb_src_o                   granted source (0/1/2)
//   stall_issue_o              issue must not send an FLU op next cycle
//   perf_collision_o           count of results captured into buffers
//
// Configuration
//   FLU_WB_ARBITER_PERF_EN     when defined, perf_collision_o is a live 32-bit
//                              wrapping counter; otherwise it is tied to 0.

module flu_wb_arbiter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     s0_valid_i,
  input  logic [XLEN-1:0]          s0_result_i,
  input  logic [TRANS_ID_BITS-1:0] s0_trans_id_i,
  input  logic                     s1_valid_i,
  input  logic [XLEN-1:0]          s1_result_i,
  input  logic [TRANS_ID_BITS-1:0] s1_trans_id_i,
  output logic                     s1_ready_o,
  input  logic                     s2_valid_i,
  input  logic [XLEN-1:0]          s2_result_i,
  input  logic [TRANS_ID_BITS-1:0] s2_trans_id_i,
  output logic                     s2_ready_o,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [1:0]               wb_src_o,
  output logic                     stall_issue_o,
  output logic [31:0]              perf_collision_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntStall = CntW'(STARVE_LIMIT - 1);

  logic                     held1_q, held1_d, held2_q, held2_d;
  logic [XLEN-1:0]          res1_q, res1_d, res2_q, res2_d;
  logic [TRANS_ID_BITS-1:0] id1_q, id1_d, id2_q, id2_d;
  logic [CntW-1:0]          cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  // 0: s1 preferred, 1: s2 preferred
  logic                     rr_q, rr_d;

  logic force1, force2, cand1, cand2;
  logic gnt_s0, gnt_s1, gnt_s2;
  logic cap1, cap2;

  assign force1 = held1_q & (cnt1_q >= CntMax);
  assign force2 = held2_q & (cnt2_q >= CntMax);
  assign cand1  = held1_q | s1_valid_i;
  assign cand2  = held2_q | s2_valid_i;

  // Forced held entries beat s0; otherwise s0 beats the round-robin pair.
  always_comb begin
    gnt_s0 = 1'b0;
    gnt_s1 = 1'b0;
    gnt_s2 = 1'b0;
    if (force1 && force2) begin
      gnt_s1 = ~rr_q;
      gnt_s2 = rr_q;
    end else if (force1) begin
      gnt_s1 = 1'b1;
    end else if (force2) begin
      gnt_s2 = 1'b1;
    end else if (s0_valid_i) begin
      gnt_s0 = 1'b1;
    end else if (cand1 && cand2) begin
      gnt_s1 = ~rr_q;
      gnt_s2 = rr_q;
    end else if (cand1) begin
      gnt_s1 = 1'b1;
    end else if (cand2) begin
      gnt_s2 = 1'b1;
    end
  end

  // Results arriving during a flush are discarded, never captured.
  assign cap1 = s1_valid_i & ~held1_q & ~gnt_s1 & ~flush_i;
  assign cap2 = s2_valid_i & ~held2_q & ~gnt_s2 & ~flush_i;

  always_comb begin
    wb_valid_o    = 1'b0;
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_src_o      = 2'd0;
    if (!flush_i) begin
      if (gnt_s0) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = s0_result_i;
        wb_trans_id_o = s0_trans_id_i;
        wb_src_o      = 2'd0;
      end else if (gnt_s1) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = held1_q ? res1_q : s1_result_i;
        wb_trans_id_o = held1_q ? id1_q : s1_trans_id_i;
        wb_src_o      = 2'd1;
      end else if (gnt_s2) begin
        wb_valid_o    = 1'b1;
        wb_result_o   = held2_q ? res2_q : s2_result_i;
        wb_trans_id_o = held2_q ? id2_q : s2_trans_id_i;
        wb_src_o      = 2'd2;
      end
    end
  end

  always_comb begin
    held1_d = held1_q;
    res1_d  = res1_q;
    id1_d   = id1_q;
    cnt1_d  = cnt1_q;
    held2_d = held2_q;
    res2_d  = res2_q;
    id2_d   = id2_q;
    cnt2_d  = cnt2_q;
    rr_d    = rr_q;
    if (flush_i) begin
      held1_d = 1'b0;
      cnt1_d  = '0;
      held2_d = 1'b0;
      cnt2_d  = '0;
      rr_d    = 1'b0;
    end else begin
      if (gnt_s1 || gnt_s2) begin
        rr_d = gnt_s1;
      end
      if (held1_q) begin
        if (gnt_s1) begin
          held1_d = 1'b0;
          cnt1_d  = '0;
        end else if (cnt1_q != CntMax) begin
          cnt1_d = cnt1_q + 1'b1;
        end
      end else if (cap1) begin
        held1_d = 1'b1;
        cnt1_d  = CntW'(1);
        res1_d  = s1_result_i;
        id1_d   = s1_trans_id_i;
      end
      if (held2_q) begin
        if (gnt_s2) begin
          held2_d = 1'b0;
          cnt2_d  = '0;
        end else if (cnt2_q != CntMax) begin
          cnt2_d = cnt2_q + 1'b1;
        end
      end else if (cap2) begin
        held2_d = 1'b1;
        cnt2_d  = CntW'(1);
        res2_d  = s2_result_i;
        id2_d   = s2_trans_id_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held1_q <= 1'b0;
      res1_q  <= '0;
      id1_q   <= '0;
      cnt1_q  <= '0;
      held2_q <= 1'b0;
      res2_q  <= '0;
      id2_q   <= '0;
      cnt2_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      held1_q <= held1_d;
      res1_q  <= res1_d;
      id1_q   <= id1_d;
      cnt1_q  <= cnt1_d;
      held2_q <= held2_d;
      res2_q  <= res2_d;
      id2_q   <= id2_d;
      cnt2_q  <= cnt2_d;
      rr_q    <= rr_d;
    end
  end

  assign s1_ready_o = ~held1_q;
  assign s2_ready_o = ~held2_q;

  // Raised one cycle before a held entry becomes forced, so s0 is idle then.
  assign stall_issue_o = (held1_q & (cnt1_q >= CntStall)) |
                         (held2_q & (cnt2_q >= CntStall));

`ifdef FLU_WB_ARBITER_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_q + {31'b0, cap1} + {31'b0, cap2};
    end
  end

  assign perf_collision_o = perf_q;
`else
  assign perf_collision_o = '0;
`endif

endmodule

// File: doc/flu_wb_arbiter.md
Name: flu_wb_arbiter

Overview:
- Arbitrates the single fixed-latency-unit (FLU) writeback port into the scoreboard between three result sources.
  - Source 0: single-cycle ALU/branch/CSR results.
  - Source 1: multiplier results.
  - Source 2: VALU results.
- Each multi-cycle source has a 1-entry holding buffer, so a result that loses arbitration is retained instead of dropped.
- A starvation guard stalls FLU issue, which guarantees that held results drain.
- Sits in ex_stage between the FLU result sources and the scoreboard writeback.

Parameters:
- XLEN, 64, result width.
- TRANS_ID_BITS, 3, scoreboard transaction ID width.
- STARVE_LIMIT, 4, cycles a held result may wait before it is forced through; must be >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  pipeline flush
- s0_valid_i  in  1  single-cycle result valid; cannot be back-pressured
- s0_result_i  in  XLEN  single-cycle result
- s0_trans_id_i  in  TRANS_ID_BITS  single-cycle ID
- s1_valid_i / s1_result_i / s1_trans_id_i  in  1/XLEN/TRANS_ID_BITS  multiplier result
- s1_ready_o  out  1  multiplier may present a result
- s2_valid_i / s2_result_i / s2_trans_id_i  in  1/XLEN/TRANS_ID_BITS  VALU result
- s2_ready_o  out  1  VALU may present a result
- wb_valid_o  out  1  writeback valid
- wb_result_o  out  XLEN  writeback data
- wb_trans_id_o  out  TRANS_ID_BITS  writeback ID
- wb_src_o  out  2  granted source (0/1/2)
- stall_issue_o  out  1  issue stage must not issue an FLU op next cycle
- perf_collision_o  out  32  collision count (see Optional Feature)

Interface decisions:
- clk_i is the only clock.
- rst_ni is the reset: asynchronous, active-low.

Behaviour:
- Reset values:
  - Buffers empty; counters 0; round-robin pointer at s1.
  - wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0, wb_src_o=0, stall_issue_o=0, s1_ready_o=1, s2_ready_o=1, perf_collision_o=0.
- Ready and source contract:
  - sk_ready_o = ~held_k_q (registered).
  - A source asserts sk_valid_i only while sk_ready_o=1; valid while not ready is illegal (bench assertion).
- Candidate for source k (k=1,2): held entry if held_k_q, else the incoming sk_valid_i and its data.
- Grant priority, evaluated combinationally each cycle:
  1. A held entry with cnt_k_q >= STARVE_LIMIT (forced). If both are forced, the round-robin pointer decides.
  2. s0, if s0_valid_i.
  3. s1/s2 candidates by round robin: the pointer names the preferred source and moves to the other source after any s1/s2 grant.
- If s0_valid_i coincides with a forced grant (issue contract broken), the s0 result is lost. Bench flags this as an error.
- Latency: 0 cycles on bypass (winning incoming result drives wb_* the same cycle); a held result is written back in a later cycle.
- Capture: an incoming s1/s2 result that is not granted is written into its buffer; held_k_q<=1, cnt_k_q<=1.
- Hold: each extra cycle held, cnt_k_q increments, saturating at STARVE_LIMIT.
- Release: a granted held entry clears held_k_q and cnt_k_q at the next edge. The source is ready again the following cycle.
- stall_issue_o = (held_1_q & cnt_1_q >= STARVE_LIMIT-1) | (held_2_q & cnt_2_q >= STARVE_LIMIT-1). This is combinational from registers only.
- No grant: wb_valid_o=0; wb_result_o, wb_trans_id_o and wb_src_o hold 0.
- Flush:
  - While flush_i=1, wb_valid_o is forced 0.
  - At the next edge, buffers, counters and the round-robin pointer are cleared; incoming results that cycle are discarded.
  - Flush takes precedence over capture and release.
- Simultaneous events:
  - s0, s1 and s2 all valid with empty buffers → s0 wins; s1 and s2 are both captured.
  - Release and new capture of the same source in one cycle cannot occur (ready is low while held).

Optional Feature:
- Macro: FLU_WB_ARBITER_PERF_EN.
- Defined: perf_collision_o is a 32-bit counter, reset 0, incremented by the number of results captured into buffers that cycle (0, 1 or 2), wrapping at 2^32. It is cleared only by reset, not by flush.
- Undefined: perf_collision_o tied to 0 and no counter logic exists.

Test Plan:
- Reset then idle → all outputs at reset values; s1_ready_o=s2_ready_o=1.
- s1 only: valid, result 0x1234, ID 5 → same cycle wb_valid_o=1, wb_result_o=0x1234, wb_trans_id_o=5, wb_src_o=1; nothing captured.
- s0 (0xA, ID 1) with s1 (0xB, ID 2) and s2 (0xC, ID 3) → cycle 0 grants s0 and captures both; cycle 1 grants s1 (pointer); cycle 2 grants s2. s1_ready_o and s2_ready_o go high after their release.
- s1 captured, then s0 valid every cycle, STARVE_LIMIT=4 → stall_issue_o rises when cnt=3. The next cycle (s0 held idle) forces the s1 grant with wb_src_o=1. The held result is never lost.
- s2 captured, flush_i pulsed → wb_valid_o=0 that cycle; next cycle s2_ready_o=1 and the held result is never written back.
- With FLU_WB_ARBITER_PERF_EN, the s0/s1/s2 collision scenario → perf_collision_o=2. Without the macro → perf_collision_o stays 0.
